// File: rtl/proc_instr_feeder_pkg.sv
// ---------------------------------------------------------------------------
// proc_instr_feeder_pkg
//   Shared ISA definitions for the processor and the instruction feeder:
//   opcode constants, instruction-register field positions and the feeder
//   state encoding. The processor, the feeder and the benches all import
//   this package so that they agree on one instruction format.
// ---------------------------------------------------------------------------
package proc_instr_feeder_pkg;

    // Opcodes, taken from IR[15:13]
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Instruction register field positions
    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int RX_HI = 12;
    localparam int RX_LO = 10;
    localparam int RY_HI = 9;
    localparam int RY_LO = 7;

    // Feeder sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_IMM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } feeder_state_t;

    // True when the opcode is the two-word immediate move
    function automatic logic is_mvi(input logic [2:0] opcode);
        return opcode == OP_MVI;
    endfunction

endpackage

// File: rtl/proc_prog_ram.sv
// ---------------------------------------------------------------------------
// proc_prog_ram
//   Program store for the instruction feeder: 2**ADDR_W words of DATA_W bits,
//   written synchronously and read asynchronously so the sequencer can look
//   at a word in the same cycle it decides whether to issue it.
// Ports
//   clock  in   single clock, write on rising edge
//   we     in   write strobe
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data
// ---------------------------------------------------------------------------
module proc_prog_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are deliberately not reset so a program survives a reset
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/proc_instr_feeder.sv
// ---------------------------------------------------------------------------
// proc_instr_feeder
//   Initiator side of the processor din/run/done interface. Holds a small
//   program, issues each word with a one-cycle run pulse, supplies the
//   immediate word of an mvi and waits for done before the next issue.
// Ports
//   clock       in   single clock, rising edge
//   reset       in   synchronous active-high reset
//   prog_we     in   program write strobe, ignored while busy
//   prog_addr   in   program write address
//   prog_wdata  in   program write data
//   prog_len    in   words to execute (0..2**ADDR_W), sampled on start
//   start       in   begin execution at address 0, ignored while busy
//   done        in   processor done, only looked at while waiting
//   din         out  word driven to the processor
//   run         out  one-cycle instruction-valid pulse
//   busy        out  high from accepted start until back in idle
//   finished    out  one-cycle pulse on normal completion
//   error       out  sticky timeout / truncated-mvi flag
//   pc          out  address of the word currently issued
// ---------------------------------------------------------------------------
module proc_instr_feeder
    import proc_instr_feeder_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    // Program counter and length are one bit wider than the RAM address so
    // that a full-depth program ends on pc == depth instead of wrapping to 0.
    localparam int            PW    = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_W);
    localparam int            CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX  = CW'(TIMEOUT - 1);

    feeder_state_t     state, state_n;
    logic [PW-1:0]     pc_int, pc_int_n;
    logic [PW-1:0]     len_q, len_n;
    logic [CW-1:0]     wait_cnt, wait_cnt_n;
    logic              cur_mvi, cur_mvi_n;
    logic [DATA_W-1:0] din_n;
    logic              run_n, busy_n, finished_n, error_n;
    logic [ADDR_W-1:0] pc_n;

    logic [PW-1:0]     len_clamped;
    logic [PW-1:0]     pc_adv;
    logic [PW-1:0]     issue_pc;
    logic [PW-1:0]     issue_len;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_mvi;
    logic              truncated;

    proc_prog_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (prog_we && (state == ST_IDLE)),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Issue lookahead: because run and din are registered, the word to be
    // issued is inspected on the edge that enters ISSUE. This lets a
    // truncated mvi be caught before any run pulse reaches the processor.
    // In ISSUE itself the RAM is pointed at pc+1 to fetch the immediate.
    assign len_clamped = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign pc_adv      = pc_int + (cur_mvi ? PW'(2) : PW'(1));
    assign issue_pc    = (state == ST_IDLE) ? '0 : pc_adv;
    assign issue_len   = (state == ST_IDLE) ? len_clamped : len_q;
    assign ram_raddr   = (state == ST_ISSUE) ? (pc_int[ADDR_W-1:0] + ADDR_W'(1))
                                             : issue_pc[ADDR_W-1:0];
    assign rd_mvi      = is_mvi(ram_rdata[OP_HI:OP_LO]);
    assign truncated   = rd_mvi && ((issue_pc + PW'(1)) == issue_len);

    // State and output registers; every output is a flop
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            pc_int   <= '0;
            len_q    <= '0;
            wait_cnt <= '0;
            cur_mvi  <= 1'b0;
            din      <= '0;
            run      <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            error    <= 1'b0;
            pc       <= '0;
        end else begin
            state    <= state_n;
            pc_int   <= pc_int_n;
            len_q    <= len_n;
            wait_cnt <= wait_cnt_n;
            cur_mvi  <= cur_mvi_n;
            din      <= din_n;
            run      <= run_n;
            busy     <= busy_n;
            finished <= finished_n;
            error    <= error_n;
            pc       <= pc_n;
        end
    end

    // Next-state and next-output logic. run and finished are pulses and
    // default low; everything else holds unless a transition changes it.
    always_comb begin
        state_n    = state;
        pc_int_n   = pc_int;
        len_n      = len_q;
        wait_cnt_n = wait_cnt;
        cur_mvi_n  = cur_mvi;
        din_n      = din;
        run_n      = 1'b0;
        busy_n     = busy;
        finished_n = 1'b0;
        error_n    = error;
        pc_n       = pc;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    len_n      = len_clamped;
                    pc_int_n   = '0;
                    pc_n       = '0;
                    wait_cnt_n = '0;
                    error_n    = 1'b0;
                    busy_n     = 1'b1;
                    if (len_clamped == '0) begin
                        state_n    = ST_FIN;
                        finished_n = 1'b1;
                    end else if (truncated) begin
                        error_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n   = ST_ISSUE;
                        run_n     = 1'b1;
                        din_n     = ram_rdata;
                        cur_mvi_n = rd_mvi;
                    end
                end
            end

            ST_ISSUE: begin
                wait_cnt_n = '0;
                if (cur_mvi) begin
                    state_n = ST_IMM;
                    din_n   = ram_rdata;
                end else begin
                    state_n = ST_WAIT;
                end
            end

            ST_IMM, ST_WAIT: begin
                if (done) begin
                    pc_int_n   = pc_adv;
                    wait_cnt_n = '0;
                    if (pc_adv >= len_q) begin
                        state_n    = ST_FIN;
                        finished_n = 1'b1;
                    end else if (truncated) begin
                        state_n = ST_IDLE;
                        error_n = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n   = ST_ISSUE;
                        run_n     = 1'b1;
                        din_n     = ram_rdata;
                        cur_mvi_n = rd_mvi;
                        pc_n      = pc_adv[ADDR_W-1:0];
                    end
                end else if (wait_cnt == TMAX) begin
                    state_n = ST_IDLE;
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    wait_cnt_n = wait_cnt + CW'(1);
                end
            end

            ST_FIN: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
